// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter sharing one downstream request/response channel.
// Each port owns a one-deep pending slot; one downstream transaction is outstanding at a time.
module bus_arbiter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_request_enable,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fetch_response_enable,
  output logic [31:0] fresp_data,
  input  logic        mem_request_enable,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mresp_data,
  output logic        request_enable,
  output logic        req_mode,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  output logic        req_source,
  input  logic        response_enable,
  input  logic [31:0] resp_data,
  output logic        busy,
  output logic        err_overflow
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_grant_fire;
  logic        w_grant_src;
  logic        w_resp_fire;
  logic        r_last_grant;

  logic        w_in_pulse [2];
  logic        w_in_mode  [2];
  logic [31:0] w_in_addr  [2];
  logic [31:0] w_in_wdata [2];
  logic [3:0]  w_in_wstrb [2];

  logic        r_slot_valid [2];
  logic        r_slot_mode  [2];
  logic [31:0] r_slot_addr  [2];
  logic [31:0] r_slot_wdata [2];
  logic [3:0]  r_slot_wstrb [2];
  logic        w_slot_clr   [2];
  logic        w_drop       [2];

  logic        r_request_enable;
  logic        r_req_mode;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic [3:0]  r_req_wstrb;
  logic        r_req_source;
  logic        r_fetch_resp_en;
  logic        r_mem_resp_en;
  logic [31:0] r_fresp_data;
  logic [31:0] r_mresp_data;
  logic        r_busy;
  logic        r_err_overflow;

  // Index 0 is the fetch port, index 1 the mem port, matching req_source encoding.
  assign w_in_pulse[0] = fetch_request_enable;
  assign w_in_mode[0]  = freq_mode;
  assign w_in_addr[0]  = freq_addr;
  assign w_in_wdata[0] = freq_wdata;
  assign w_in_wstrb[0] = freq_wstrb;
  assign w_in_pulse[1] = mem_request_enable;
  assign w_in_mode[1]  = mreq_mode;
  assign w_in_addr[1]  = mreq_addr;
  assign w_in_wdata[1] = mreq_wdata;
  assign w_in_wstrb[1] = mreq_wstrb;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, grant selection and response detection.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_fire = 1'b0;
    w_grant_src  = 1'b0;
    w_resp_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_slot_valid[0] || r_slot_valid[1]) begin
          w_grant_fire = 1'b1;
          w_state_nxt  = ST_WAIT;
          if (r_slot_valid[0] && r_slot_valid[1]) begin
            w_grant_src = ~r_last_grant;
          end else begin
            w_grant_src = r_slot_valid[1];
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (response_enable) begin
          w_resp_fire = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Slot of the granted port is freed on the edge its response is accepted.
  always_comb begin
    w_slot_clr[0] = 1'b0;
    w_slot_clr[1] = 1'b0;
    if (w_resp_fire) begin
      w_slot_clr[0] = ~r_req_source;
      w_slot_clr[1] = r_req_source;
    end else begin
      w_slot_clr[0] = 1'b0;
      w_slot_clr[1] = 1'b0;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_slot
    // A freed slot can be refilled on the same edge it clears.
    assign w_drop[g] = w_in_pulse[g] & r_slot_valid[g] & ~w_slot_clr[g];

    // Per-port pending request slot.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_slot_valid[g] <= 1'b0;
        r_slot_mode[g]  <= 1'b0;
        r_slot_addr[g]  <= 32'h0000_0000;
        r_slot_wdata[g] <= 32'h0000_0000;
        r_slot_wstrb[g] <= 4'h0;
      end else if (w_in_pulse[g] && !w_drop[g]) begin
        r_slot_valid[g] <= 1'b1;
        r_slot_mode[g]  <= w_in_mode[g];
        r_slot_addr[g]  <= w_in_addr[g];
        r_slot_wdata[g] <= w_in_wdata[g];
        r_slot_wstrb[g] <= w_in_wstrb[g];
      end else if (w_slot_clr[g]) begin
        r_slot_valid[g] <= 1'b0;
      end
    end
  end

  // Downstream request fields, held from one grant to the next.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_request_enable <= 1'b0;
      r_req_mode       <= 1'b0;
      r_req_addr       <= 32'h0000_0000;
      r_req_wdata      <= 32'h0000_0000;
      r_req_wstrb      <= 4'h0;
      r_req_source     <= 1'b0;
      r_last_grant     <= 1'b1;
    end else begin
      r_request_enable <= w_grant_fire;
      if (w_grant_fire) begin
        r_req_mode   <= r_slot_mode[w_grant_src];
        r_req_addr   <= r_slot_addr[w_grant_src];
        r_req_wdata  <= r_slot_wdata[w_grant_src];
        r_req_wstrb  <= r_slot_wstrb[w_grant_src];
        r_req_source <= w_grant_src;
        r_last_grant <= w_grant_src;
      end
    end
  end

  // Upstream responses, status and the sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_resp_en <= 1'b0;
      r_mem_resp_en   <= 1'b0;
      r_fresp_data    <= 32'h0000_0000;
      r_mresp_data    <= 32'h0000_0000;
      r_busy          <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else begin
      r_fetch_resp_en <= w_resp_fire & ~r_req_source;
      r_mem_resp_en   <= w_resp_fire & r_req_source;
      if (w_resp_fire && !r_req_source) begin
        r_fresp_data <= resp_data;
      end
      if (w_resp_fire && r_req_source) begin
        r_mresp_data <= resp_data;
      end
      r_busy <= (w_state_nxt == ST_WAIT);
      if (w_drop[0] || w_drop[1]) begin
        r_err_overflow <= 1'b1;
      end
    end
  end

  assign request_enable        = r_request_enable;
  assign req_mode              = r_req_mode;
  assign req_addr              = r_req_addr;
  assign req_wdata             = r_req_wdata;
  assign req_wstrb             = r_req_wstrb;
  assign req_source            = r_req_source;
  assign fetch_response_enable = r_fetch_resp_en;
  assign mem_response_enable   = r_mem_resp_en;
  assign fresp_data            = r_fresp_data;
  assign mresp_data            = r_mresp_data;
  assign busy                  = r_busy;
  assign err_overflow          = r_err_overflow;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model.
module tb_bus_arbiter;
  logic        clk;
  logic        rstn;
  logic        fetch_request_enable, freq_mode;
  logic [31:0] freq_addr, freq_wdata;
  logic [3:0]  freq_wstrb;
  logic        fetch_response_enable;
  logic [31:0] fresp_data;
  logic        mem_request_enable, mreq_mode;
  logic [31:0] mreq_addr, mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mem_response_enable;
  logic [31:0] mresp_data;
  logic        request_enable, req_mode, req_source;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        busy, err_overflow;

  bus_arbiter dut (
    .clk(clk), .rstn(rstn),
    .fetch_request_enable(fetch_request_enable), .freq_mode(freq_mode),
    .freq_addr(freq_addr), .freq_wdata(freq_wdata), .freq_wstrb(freq_wstrb),
    .fetch_response_enable(fetch_response_enable), .fresp_data(fresp_data),
    .mem_request_enable(mem_request_enable), .mreq_mode(mreq_mode),
    .mreq_addr(mreq_addr), .mreq_wdata(mreq_wdata), .mreq_wstrb(mreq_wstrb),
    .mem_response_enable(mem_response_enable), .mresp_data(mresp_data),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_source(req_source),
    .response_enable(response_enable), .resp_data(resp_data),
    .busy(busy), .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        src;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    int          cyc;
    logic        src;
    logic [31:0] data;
  } rsp_t;

  req_t        exp_req[$];
  rsp_t        exp_rsp[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  // Reference model: per-port pending request, at most one transaction outstanding.
  req_t        slot [2];
  bit          slot_v [2];
  bit          m_busy = 1'b0;
  bit          m_last = 1'b1;
  bit          m_ovf  = 1'b0;
  req_t        m_cur;
  logic [31:0] m_fresp = 32'h0;
  logic [31:0] m_mresp = 32'h0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    slot_v[0] = 1'b0;
    slot_v[1] = 1'b0;
    m_busy    = 1'b0;
    m_last    = 1'b1;
    m_ovf     = 1'b0;
    m_cur     = '{cyc: 0, src: 1'b0, mode: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0};
    m_fresp   = 32'h0;
    m_mresp   = 32'h0;
    exp_req.delete();
    exp_rsp.delete();
  endfunction

  initial model_reset();

  always @(posedge clk or negedge rstn) begin : model
    req_t inc [2];
    bit   pulse [2];
    bit   g;
    rsp_t r;
    if (!rstn) begin
      model_reset();
    end else begin
      cyc++;
      inc[0] = '{cyc: cyc, src: 1'b0, mode: freq_mode, addr: freq_addr, wdata: freq_wdata, wstrb: freq_wstrb};
      inc[1] = '{cyc: cyc, src: 1'b1, mode: mreq_mode, addr: mreq_addr, wdata: mreq_wdata, wstrb: mreq_wstrb};
      pulse[0] = fetch_request_enable;
      pulse[1] = mem_request_enable;
      if (!m_busy) begin
        if (slot_v[0] || slot_v[1]) begin
          g = (slot_v[0] && slot_v[1]) ? ~m_last : slot_v[1];
          m_cur     = slot[g];
          m_cur.src = g;
          m_cur.cyc = cyc;
          m_last    = g;
          m_busy    = 1'b1;
          exp_req.push_back(m_cur);
        end
      end else if (response_enable) begin
        if (m_cur.src) m_mresp = resp_data;
        else m_fresp = resp_data;
        r.cyc  = cyc;
        r.src  = m_cur.src;
        r.data = resp_data;
        exp_rsp.push_back(r);
        slot_v[m_cur.src] = 1'b0;
        m_busy = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (pulse[p]) begin
          if (slot_v[p]) begin
            m_ovf = 1'b1;
          end else begin
            slot_v[p] = 1'b1;
            slot[p]   = inc[p];
          end
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    req_t e;
    rsp_t r;
    logic any_rsp;
    if (rstn) begin
      if (request_enable) begin
        if (exp_req.size() == 0) begin
          chk32("req_unexpected", exp_req.size(), 32'd1);
        end else begin
          e = exp_req.pop_front();
          chk32("req_cycle", cyc, e.cyc);
          chk1("req_source", req_source, e.src);
          chk1("req_mode", req_mode, e.mode);
          chk32("req_addr", req_addr, e.addr);
          chk32("req_wdata", req_wdata, e.wdata);
          chk32("req_wstrb", {28'h0, req_wstrb}, {28'h0, e.wstrb});
        end
      end
      if (exp_req.size() > 0 && exp_req[0].cyc <= cyc) begin
        chk1("req_missing", request_enable, 1'b1);
        e = exp_req.pop_front();
      end
      any_rsp = fetch_response_enable | mem_response_enable;
      if (any_rsp) begin
        if (exp_rsp.size() == 0) begin
          chk32("rsp_unexpected", exp_rsp.size(), 32'd1);
        end else begin
          r = exp_rsp.pop_front();
          chk32("rsp_cycle", cyc, r.cyc);
          chk1("rsp_port", mem_response_enable, r.src);
          chk1("rsp_single", fetch_response_enable & mem_response_enable, 1'b0);
          chk32("rsp_data", mem_response_enable ? mresp_data : fresp_data, r.data);
        end
      end
      if (exp_rsp.size() > 0 && exp_rsp[0].cyc <= cyc) begin
        chk1("rsp_missing", any_rsp, 1'b1);
        r = exp_rsp.pop_front();
      end
      chk1("busy", busy, m_busy);
      chk1("err_overflow", err_overflow, m_ovf);
      chk1("hold_source", req_source, m_cur.src);
      chk32("hold_addr", req_addr, m_cur.addr);
      chk32("hold_wdata", req_wdata, m_cur.wdata);
      chk32("hold_fresp", fresp_data, m_fresp);
      chk32("hold_mresp", mresp_data, m_mresp);
    end
  end

  task automatic step();
    @(negedge clk);
    fetch_request_enable = 1'b0;
    mem_request_enable   = 1'b0;
    response_enable      = 1'b0;
  endtask

  task automatic set_fetch(input logic mode, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
    fetch_request_enable = 1'b1;
    freq_mode  = mode;
    freq_addr  = addr;
    freq_wdata = wdata;
    freq_wstrb = wstrb;
  endtask

  task automatic set_mem(input logic mode, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
    mem_request_enable = 1'b1;
    mreq_mode  = mode;
    mreq_addr  = addr;
    mreq_wdata = wdata;
    mreq_wstrb = wstrb;
  endtask

  task automatic respond(input logic [31:0] d);
    response_enable = 1'b1;
    resp_data       = d;
    step();
  endtask

  task automatic async_reset_check(input string tag);
    #2 rstn = 1'b0;
    #1;
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_ovf"}, err_overflow, 1'b0);
    chk1({tag, "_reqen"}, request_enable, 1'b0);
    chk1({tag, "_src"}, req_source, 1'b0);
    chk32({tag, "_addr"}, req_addr, 32'h0);
    chk32({tag, "_fresp"}, fresp_data, 32'h0);
    chk32({tag, "_mresp"}, mresp_data, 32'h0);
    @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    fetch_request_enable = 1'b0; freq_mode = 1'b0; freq_addr = 32'h0; freq_wdata = 32'h0; freq_wstrb = 4'h0;
    mem_request_enable = 1'b0; mreq_mode = 1'b0; mreq_addr = 32'h0; mreq_wdata = 32'h0; mreq_wstrb = 4'h0;
    response_enable = 1'b0; resp_data = 32'h0;
    repeat (2) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_reqen", request_enable, 1'b0);
    chk1("rst_ovf", err_overflow, 1'b0);
    chk32("rst_addr", req_addr, 32'h0);
    #2 rstn = 1'b1;
    step();

    // Basic fetch read with exact latency.
    set_fetch(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    step();
    chk1("lat_early", request_enable, 1'b0);
    step();
    chk1("lat_grant", request_enable, 1'b1);
    chk1("r31_mode", req_mode, 1'b0);
    chk1("r31_src", req_source, 1'b0);
    chk32("r31_addr", req_addr, 32'h0000_1000);
    chk1("r31_busy", busy, 1'b1);
    respond(32'hDEAD_BEEF);
    chk1("r31_rsp", fetch_response_enable, 1'b1);
    chk32("r31_data", fresp_data, 32'hDEAD_BEEF);
    chk1("r31_idle", busy, 1'b0);
    step();
    chk1("r31_pulse_once", fetch_response_enable, 1'b0);

    // Response while idle is ignored.
    respond(32'h5555_AAAA);
    chk1("r36_frsp", fetch_response_enable, 1'b0);
    chk1("r36_mrsp", mem_response_enable, 1'b0);
    chk1("r36_busy", busy, 1'b0);
    chk32("r36_fhold", fresp_data, 32'hDEAD_BEEF);

    // Mem write field pass-through.
    set_mem(1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF);
    step();
    step();
    chk1("r33_reqen", request_enable, 1'b1);
    chk1("r33_mode", req_mode, 1'b1);
    chk1("r33_src", req_source, 1'b1);
    chk32("r33_addr", req_addr, 32'h8000_0000);
    chk32("r33_wdata", req_wdata, 32'h1234_5678);
    chk32("r33_wstrb", {28'h0, req_wstrb}, 32'h0000_000F);
    respond(32'hCAFE_0001);
    chk1("r33_rsp", mem_response_enable, 1'b1);
    chk32("r33_data", mresp_data, 32'hCAFE_0001);
    step();

    // Round-robin ties.
    set_fetch(1'b0, 32'h0000_2000, 32'h0, 4'h0);
    set_mem(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    step();
    step();
    chk1("tie1_fetch_first", req_source, 1'b0);
    respond(32'h1111_1111);
    chk1("tie1_frsp", fetch_response_enable, 1'b1);
    step();
    chk1("tie1_mem_grant", request_enable, 1'b1);
    chk1("tie1_mem_second", req_source, 1'b1);
    chk32("tie1_mem_addr", req_addr, 32'h0000_3000);
    respond(32'h2222_2222);
    chk1("tie1_mrsp", mem_response_enable, 1'b1);
    step();
    set_fetch(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    step();
    step();
    respond(32'h3333_3333);
    step();
    set_fetch(1'b0, 32'h0000_5000, 32'h0, 4'h0);
    set_mem(1'b1, 32'h0000_6000, 32'hABCD_0000, 4'h3);
    step();
    step();
    chk1("tie2_mem_first", req_source, 1'b1);
    respond(32'h4444_4444);
    step();
    chk1("tie2_fetch_second", req_source, 1'b0);
    respond(32'h5555_5555);
    step();

    // Overflow drop and sticky flag.
    set_fetch(1'b0, 32'h0000_7000, 32'h0, 4'h0);
    step();
    chk1("ovf_clear", err_overflow, 1'b0);
    set_fetch(1'b1, 32'h0000_7777, 32'hFFFF_FFFF, 4'hF);
    step();
    chk1("ovf_set", err_overflow, 1'b1);
    chk32("ovf_first_addr", req_addr, 32'h0000_7000);
    respond(32'h7070_7070);
    chk32("ovf_first_rsp", fresp_data, 32'h7070_7070);
    step();
    chk1("ovf_sticky", err_overflow, 1'b1);
    chk1("ovf_no_regrant", request_enable, 1'b0);

    // Reset while waiting abandons the transaction.
    set_fetch(1'b0, 32'h0000_9000, 32'h0, 4'h0);
    step();
    step();
    chk1("r35_wait", busy, 1'b1);
    async_reset_check("r35");
    response_enable = 1'b1;
    resp_data       = 32'h9999_9999;
    step();
    chk1("r35_no_frsp", fetch_response_enable, 1'b0);
    chk1("r35_no_mrsp", mem_response_enable, 1'b0);
    chk1("r35_busy", busy, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      fetch_request_enable = ($urandom_range(0, 3) == 0);
      freq_mode  = 1'($urandom_range(0, 1));
      freq_addr  = $urandom;
      freq_wdata = $urandom;
      freq_wstrb = 4'($urandom);
      mem_request_enable = ($urandom_range(0, 3) == 0);
      mreq_mode  = 1'($urandom_range(0, 1));
      mreq_addr  = $urandom;
      mreq_wdata = $urandom;
      mreq_wstrb = 4'($urandom);
      response_enable = ($urandom_range(0, 2) == 0);
      resp_data  = $urandom;
      @(negedge clk);
      if (i == 1500) async_reset_check("rand_rst");
    end
    repeat (5) step();
    chk32("drain", exp_req.size() + exp_rsp.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 fetch_request_enable  input  1  fetch-port request pulse, one cycle.
REQ-005 freq_mode / freq_addr / freq_wdata / freq_wstrb  input  1/32/32/4  fetch request (mode 0=read, 1=write), valid with pulse.
REQ-006 fetch_response_enable  output  1  fetch-port response pulse.
REQ-007 fresp_data  output  32  fetch response data, valid with pulse.
REQ-008 mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb  input  1/1/32/32/4  mem-port request, same rules as fetch.
REQ-009 mem_response_enable, mresp_data  output  1/32  mem-port response pulse and data.
REQ-010 request_enable  output  1  downstream request pulse.
REQ-011 req_mode, req_addr, req_wdata, req_wstrb  output  1/32/32/4  downstream request fields.
REQ-012 req_source  output  1  granted port (0=fetch, 1=mem).
REQ-013 response_enable, resp_data  input  1/32  downstream response pulse and data.
REQ-014 busy  output  1  high while FSM is not IDLE.
REQ-015 err_overflow  output  1  sticky flag: request dropped on a full slot.

Function
REQ-016 Each port SHALL have a one-deep pending slot (valid + mode, addr, wdata, wstrb), loaded on the edge the request pulse is sampled.
REQ-017 A request pulse on a port with a valid slot SHALL be dropped, leave the slot unchanged, and set err_overflow until reset.
REQ-018 FSM states SHALL be IDLE and WAIT only.
REQ-019 IDLE: with at least one valid slot, next edge grants one port, registers its fields onto req_*, sets req_source, pulses request_enable high for exactly one cycle, and enters WAIT.
REQ-020 Arbitration SHALL be round-robin: only one slot valid, grant it; both valid, grant the port not granted last; last_grant register resets to 1 (mem), so fetch wins the first tie.
REQ-021 Slots are registered state: a pulse sampled at edge E0 is arbitrated in the cycle after E0, and request_enable is high after edge E1 (2-edge minimum request latency).
REQ-022 WAIT: on response_enable, the next edge pulses the granted port's *_response_enable for one cycle, copies resp_data to its data output, clears its slot, and returns to IDLE.
REQ-023 A new request on the same edge its port's slot clears SHALL be latched into the freed slot.
REQ-024 The non-granted port SHALL accept and hold a request throughout WAIT; it is arbitrated on the IDLE cycle after return.
REQ-025 response_enable in IDLE SHALL be ignored, with no output change.
REQ-026 req_* and req_source SHALL hold their values from grant until the next grant.
REQ-027 fresp_data / mresp_data SHALL hold their values until that port's next response.
REQ-028 Response-pulse, request-pulse and data outputs SHALL all be registered.

Reset
REQ-029 rstn low SHALL immediately clear the FSM to IDLE, both slots, every *_enable output, busy, err_overflow and all data/field outputs to 0, and set last_grant=1.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; a later response_enable is then ignored (IDLE).

Verification
REQ-031 Fetch read addr 0x0000_1000 -> request_enable 2 edges later, req_mode=0, req_source=0; response 0xDEADBEEF -> fetch_response_enable next cycle, fresp_data=0xDEADBEEF.
REQ-032 Fetch and mem requests in the same cycle -> fetch granted first, mem granted on the IDLE cycle after the fetch response; a second tie -> mem first.
REQ-033 Mem write addr 0x8000_0000, wdata 0x12345678, wstrb 0xF -> downstream fields match exactly, req_mode=1, req_source=1.
REQ-034 Second fetch pulse while the fetch slot is valid -> dropped; err_overflow=1 sticky; the first request completes normally.
REQ-035 rstn asserted while in WAIT -> all outputs 0 immediately; a following response_enable produces no response pulse.
REQ-036 response_enable while IDLE -> no *_response_enable pulse; busy stays 0.
